// File: rtl/grid_access_arbiter_if.sv
// Signal bundle between grid_access_arbiter and its users: display scan, game logic and grid RAM.
// The slave modport is the arbiter side; master is the surrounding system.
interface grid_access_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
);
  logic              game_start;
  logic              busy_clear;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              disp_miss;
  logic              gm_req;
  logic              gm_we;
  logic [ADDR_W-1:0] gm_addr;
  logic [DATA_W-1:0] gm_wdata;
  logic              gm_ack;
  logic [DATA_W-1:0] gm_rdata;
  logic              gm_rvalid;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  game_start, disp_req, disp_addr, gm_req, gm_we, gm_addr, gm_wdata, ram_rdata,
    output busy_clear, disp_data, disp_valid, disp_miss, gm_ack, gm_rdata, gm_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output game_start, disp_req, disp_addr, gm_req, gm_we, gm_addr, gm_wdata, ram_rdata,
    input  busy_clear, disp_data, disp_valid, disp_miss, gm_ack, gm_rdata, gm_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/grid_access_arbiter.sv
// Single-port grid RAM arbiter: clear sequencer > starved game > display > game.
// Decision at N, RAM at N+1, read data at N+2, registered results at N+3.
module grid_access_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 4,
  parameter int CELLS      = 768,
  parameter int CLEAR_VAL  = 0,
  parameter int STARVE_MAX = 1024
) (
  input logic                  clk,
  input logic                  rst,
  grid_access_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  localparam logic [1:0] K_RAM  = 2'd0;
  localparam logic [1:0] K_CLR  = 2'd1;
  localparam logic [1:0] K_OOR  = 2'd2;
  localparam logic [1:0] K_MISS = 2'd3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_W   = (ADDR_W + 1)'(CELLS);
  localparam logic [DATA_W-1:0] CLR_D     = DATA_W'(CLEAR_VAL);
  localparam logic [CNT_W-1:0]  WAIT_MAX  = CNT_W'(STARVE_MAX);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [CNT_W-1:0]  r_wait;
  logic              r_ram_en, r_ram_we, r_gm_ack;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_s1_dv, r_s2_dv, r_s1_grd, r_s2_grd, r_s1_goor, r_s2_goor;
  logic [1:0]        r_s1_dk, r_s2_dk;
  logic              r_disp_valid, r_disp_miss, r_gm_rvalid;
  logic [DATA_W-1:0] r_disp_data, r_gm_rdata;

  logic              w_clear, w_start, w_gm_ok, w_force, w_gm_gnt, w_disp_gnt;
  logic              w_disp_oor, w_gm_oor, w_en, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [1:0]        w_dk;

  assign w_clear    = (r_state == S_CLEAR);
  assign w_start    = (r_state == S_IDLE) && bus.game_start;
  assign w_disp_oor = ({1'b0, bus.disp_addr} >= CELLS_W);
  assign w_gm_oor   = ({1'b0, bus.gm_addr} >= CELLS_W);
  // The cycle that launches a clear also holds off the game, so its request waits out the clear.
  assign w_gm_ok    = bus.gm_req && !r_gm_ack && !w_clear && !w_start;
  assign w_force    = w_gm_ok && (r_wait == WAIT_MAX);
  assign w_disp_gnt = bus.disp_req && !w_clear && !w_force;
  assign w_gm_gnt   = w_force || (w_gm_ok && !bus.disp_req);

  always_comb begin
    w_en    = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_dk    = K_RAM;
    if (w_clear) begin
      w_en    = 1'b1;
      w_we    = 1'b1;
      w_addr  = r_clr_cnt;
      w_wdata = CLR_D;
    end else if (w_gm_gnt) begin
      w_en    = !w_gm_oor;
      w_we    = bus.gm_we && !w_gm_oor;
      w_addr  = bus.gm_addr;
      w_wdata = bus.gm_wdata;
    end else if (w_disp_gnt) begin
      w_en    = !w_disp_oor;
      w_addr  = bus.disp_addr;
    end
    if (w_clear)         w_dk = K_CLR;
    else if (w_force)    w_dk = K_MISS;
    else if (w_disp_oor) w_dk = K_OOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_clr_cnt    <= '0;
      r_wait       <= '0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_gm_ack     <= 1'b0;
      r_s1_dv      <= 1'b0;
      r_s2_dv      <= 1'b0;
      r_s1_dk      <= K_RAM;
      r_s2_dk      <= K_RAM;
      r_s1_grd     <= 1'b0;
      r_s2_grd     <= 1'b0;
      r_s1_goor    <= 1'b0;
      r_s2_goor    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_miss  <= 1'b0;
      r_disp_data  <= '0;
      r_gm_rvalid  <= 1'b0;
      r_gm_rdata   <= '0;
    end else begin
      if (w_start) begin
        r_state   <= S_CLEAR;
        r_clr_cnt <= '0;
      end else if (w_clear) begin
        if (r_clr_cnt == LAST_ADDR) begin
          r_state   <= S_IDLE;
          r_clr_cnt <= '0;
        end else begin
          r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
        end
      end

      if (w_gm_gnt || !bus.gm_req)
        r_wait <= '0;
      else if (!r_gm_ack && r_wait != WAIT_MAX)
        r_wait <= r_wait + CNT_W'(1);

      r_ram_en    <= w_en;
      r_ram_we    <= w_we;
      r_ram_addr  <= w_addr;
      r_ram_wdata <= w_wdata;
      r_gm_ack    <= w_gm_gnt;

      r_s1_dv   <= bus.disp_req;
      r_s1_dk   <= w_dk;
      r_s1_grd  <= w_gm_gnt && !bus.gm_we;
      r_s1_goor <= w_gm_oor;
      r_s2_dv   <= r_s1_dv;
      r_s2_dk   <= r_s1_dk;
      r_s2_grd  <= r_s1_grd;
      r_s2_goor <= r_s1_goor;

      r_disp_valid <= r_s2_dv;
      r_disp_miss  <= r_s2_dv && (r_s2_dk == K_MISS);
      if (r_s2_dv) begin
        case (r_s2_dk)
          K_RAM:   r_disp_data <= bus.ram_rdata;
          K_CLR:   r_disp_data <= CLR_D;
          K_OOR:   r_disp_data <= '0;
          default: r_disp_data <= r_disp_data;
        endcase
      end
      r_gm_rvalid <= r_s2_grd;
      if (r_s2_grd)
        r_gm_rdata <= r_s2_goor ? '0 : bus.ram_rdata;
    end
  end

  assign bus.busy_clear = (r_state == S_CLEAR);
  assign bus.ram_en     = r_ram_en;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.gm_ack     = r_gm_ack;
  assign bus.gm_rdata   = r_gm_rdata;
  assign bus.gm_rvalid  = r_gm_rvalid;
  assign bus.disp_data  = r_disp_data;
  assign bus.disp_valid = r_disp_valid;
  assign bus.disp_miss  = r_disp_miss;
endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed bench for grid_access_arbiter with a behavioural single-port grid RAM.
module tb_grid_access_arbiter;
  localparam int ADDR_W = 10, DATA_W = 4, CELLS = 768, STARVE_MAX = 1024;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  grid_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  grid_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CELLS(CELLS), .CLEAR_VAL(0), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.game_start = 0; bus.disp_req = 0; bus.disp_addr = '0;
    bus.gm_req = 0; bus.gm_we = 0; bus.gm_addr = '0; bus.gm_wdata = '0;
    repeat (3) tick;
    tests++;
    if ({bus.busy_clear, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.gm_ack,
         bus.gm_rvalid, bus.gm_rdata, bus.disp_valid, bus.disp_miss, bus.disp_data} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    rst = 1'b0;
    tick;
    tests++;
    if ({bus.busy_clear, bus.ram_en} !== 2'b00) begin
      fails++; $display("FAIL no_auto_clear: busy/en=%b required 00", {bus.busy_clear, bus.ram_en});
    end
  endtask

  task automatic test_clear;
    bus.game_start = 1;
    tick;
    bus.game_start = 0;
    tests++;
    if (bus.ram_en !== 1'b0) begin
      fails++; $display("FAIL clear_start_idle: ram_en=%b required 0", bus.ram_en);
    end
    for (int i = 0; i < CELLS; i++) begin
      tests++;
      if (bus.busy_clear !== 1'b1) begin
        fails++; $display("FAIL clear_busy[%0d]: busy_clear=%b required 1", i, bus.busy_clear);
      end
      tick;
      tests++;
      if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 1'b1, ADDR_W'(i), 4'h0}) begin
        fails++; $display("FAIL clear_write[%0d]: en=%b we=%b addr=%0d wdata=%0d required 1 1 %0d 0",
                          i, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, i);
      end
    end
    tests++;
    if (bus.busy_clear !== 1'b0) begin
      fails++; $display("FAIL clear_end_busy: busy_clear=%b required 0", bus.busy_clear);
    end
    tick;
    tests++;
    if ({bus.ram_en, bus.ram_we} !== 2'b00) begin
      fails++; $display("FAIL clear_end_ram: en/we=%b required 00", {bus.ram_en, bus.ram_we});
    end
  endtask

  task automatic test_game_rw;
    bus.gm_req = 1; bus.gm_we = 1; bus.gm_addr = 10'd5; bus.gm_wdata = 4'd3;
    tick;
    tests++;
    if ({bus.gm_ack, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {3'b111, 10'd5, 4'd3}) begin
      fails++; $display("FAIL gm_write_ack: ack=%b en=%b we=%b addr=%0d wdata=%0d required 1 1 1 5 3",
                        bus.gm_ack, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    bus.gm_we = 0;
    tick;
    tests++;
    if (bus.gm_ack !== 1'b0) begin
      fails++; $display("FAIL gm_no_double_grant: gm_ack=%b required 0", bus.gm_ack);
    end
    tick;
    tests++;
    if ({bus.gm_ack, bus.gm_rvalid} !== 2'b10) begin
      fails++; $display("FAIL gm_read_ack: ack/rvalid=%b required 10", {bus.gm_ack, bus.gm_rvalid});
    end
    bus.gm_req = 0;
    tick;
    tick;
    tests++;
    if ({bus.gm_rvalid, bus.gm_rdata} !== {1'b1, 4'd3}) begin
      fails++; $display("FAIL gm_read_data: rvalid=%b rdata=%0d required 1 3", bus.gm_rvalid, bus.gm_rdata);
    end
    tick;
    tests++;
    if (bus.gm_rvalid !== 1'b0) begin
      fails++; $display("FAIL gm_rvalid_pulse: rvalid=%b required 0", bus.gm_rvalid);
    end
  endtask

  task automatic test_disp_stream;
    for (int i = 0; i < 32; i++) begin
      bus.gm_req = 1; bus.gm_we = 1; bus.gm_addr = ADDR_W'(i); bus.gm_wdata = DATA_W'(i % 16);
      tick;
      tests++;
      if (bus.gm_ack !== 1'b1) begin
        fails++; $display("FAIL preload_ack[%0d]: gm_ack=%b required 1", i, bus.gm_ack);
      end
      bus.gm_req = 0;
      tick;
    end
    for (int c = 0; c < 35; c++) begin
      bus.disp_req  = (c < 32);
      bus.disp_addr = ADDR_W'(c % 32);
      if (c >= 3) begin
        tests++;
        if ({bus.disp_valid, bus.disp_miss, bus.disp_data} !== {2'b10, DATA_W'((c - 3) % 16)}) begin
          fails++; $display("FAIL disp_stream[%0d]: valid=%b miss=%b data=%0d required 1 0 %0d",
                            c, bus.disp_valid, bus.disp_miss, bus.disp_data, (c - 3) % 16);
        end
      end
      tick;
    end
    tests++;
    if (bus.disp_valid !== 1'b0) begin
      fails++; $display("FAIL disp_stream_end: valid=%b required 0", bus.disp_valid);
    end
  endtask

  task automatic test_starvation;
    int ack_k;
    ack_k = -1;
    bus.disp_req = 1; bus.disp_addr = '0;
    bus.gm_req = 1; bus.gm_we = 0; bus.gm_addr = 10'd7;
    for (int k = 1; k <= 1032; k++) begin
      tick;
      if (bus.gm_ack === 1'b1 && ack_k < 0) begin
        ack_k = k;
        bus.gm_req = 0;
      end
      if (k == 1026) begin
        tests++;
        if ({bus.disp_valid, bus.disp_miss, bus.disp_data} !== {2'b10, 4'd15}) begin
          fails++; $display("FAIL starve_pre: valid=%b miss=%b data=%0d required 1 0 15",
                            bus.disp_valid, bus.disp_miss, bus.disp_data);
        end
      end
      if (k == 1027) begin
        tests++;
        if ({bus.disp_valid, bus.disp_miss, bus.disp_data} !== {2'b11, 4'd15}) begin
          fails++; $display("FAIL starve_miss: valid=%b miss=%b data=%0d required 1 1 15",
                            bus.disp_valid, bus.disp_miss, bus.disp_data);
        end
        tests++;
        if ({bus.gm_rvalid, bus.gm_rdata} !== {1'b1, 4'd7}) begin
          fails++; $display("FAIL starve_gm_read: rvalid=%b rdata=%0d required 1 7", bus.gm_rvalid, bus.gm_rdata);
        end
      end
      if (k == 1028) begin
        tests++;
        if ({bus.disp_valid, bus.disp_miss, bus.disp_data} !== {2'b10, 4'd1}) begin
          fails++; $display("FAIL starve_post: valid=%b miss=%b data=%0d required 1 0 1",
                            bus.disp_valid, bus.disp_miss, bus.disp_data);
        end
      end
      bus.disp_addr = ADDR_W'(k % 32);
      bus.disp_req  = (k <= 1029);
    end
    bus.gm_req = 0;
    tests++;
    if (ack_k !== STARVE_MAX + 1) begin
      fails++; $display("FAIL starve_ack_cycle: ack after %0d cycles required %0d", ack_k, STARVE_MAX + 1);
    end
  endtask

  task automatic test_clear_conflict;
    int ack_k;
    ack_k = -1;
    bus.game_start = 1;
    bus.gm_req = 1; bus.gm_we = 1; bus.gm_addr = 10'd10; bus.gm_wdata = 4'd9;
    for (int k = 1; k <= 800; k++) begin
      tick;
      bus.game_start = 0;
      if (bus.gm_ack === 1'b1 && ack_k < 0) begin
        ack_k = k;
        bus.gm_req = 0;
      end
      if (k == 8) begin
        tests++;
        if ({bus.disp_valid, bus.disp_miss, bus.disp_data} !== {2'b10, 4'd0}) begin
          fails++; $display("FAIL clear_disp: valid=%b miss=%b data=%0d required 1 0 0",
                            bus.disp_valid, bus.disp_miss, bus.disp_data);
        end
      end
      bus.disp_req  = (k == 5);
      bus.disp_addr = 10'd10;
    end
    tests++;
    if (ack_k !== CELLS + 2) begin
      fails++; $display("FAIL clear_gm_wait: ack at cycle %0d required %0d", ack_k, CELLS + 2);
    end
  endtask

  task automatic test_oor;
    bus.gm_req = 1; bus.gm_we = 0; bus.gm_addr = 10'd800;
    tick;
    tests++;
    if ({bus.gm_ack, bus.ram_en} !== 2'b10) begin
      fails++; $display("FAIL oor_gm_ack: ack/en=%b required 10", {bus.gm_ack, bus.ram_en});
    end
    bus.gm_req = 0;
    tick;
    tick;
    tests++;
    if ({bus.gm_rvalid, bus.gm_rdata} !== {1'b1, 4'd0}) begin
      fails++; $display("FAIL oor_gm_read: rvalid=%b rdata=%0d required 1 0", bus.gm_rvalid, bus.gm_rdata);
    end
    bus.disp_req = 1; bus.disp_addr = 10'd10;
    tick;
    bus.disp_addr = 10'd900;
    tick;
    bus.disp_req = 0;
    tests++;
    if (bus.ram_en !== 1'b0) begin
      fails++; $display("FAIL oor_disp_noram: ram_en=%b required 0", bus.ram_en);
    end
    tick;
    tests++;
    if ({bus.disp_valid, bus.disp_data} !== {1'b1, 4'd9}) begin
      fails++; $display("FAIL oor_disp_prev: valid=%b data=%0d required 1 9", bus.disp_valid, bus.disp_data);
    end
    tick;
    tests++;
    if ({bus.disp_valid, bus.disp_miss, bus.disp_data} !== {2'b10, 4'd0}) begin
      fails++; $display("FAIL oor_disp: valid=%b miss=%b data=%0d required 1 0 0",
                        bus.disp_valid, bus.disp_miss, bus.disp_data);
    end
  endtask

  task automatic test_reset_mid_clear;
    bus.game_start = 1;
    tick;
    bus.game_start = 0;
    repeat (10) tick;
    tests++;
    if ({bus.busy_clear, bus.ram_we} !== 2'b11) begin
      fails++; $display("FAIL midclear_active: busy/we=%b required 11", {bus.busy_clear, bus.ram_we});
    end
    rst = 1;
    tick;
    tests++;
    if ({bus.busy_clear, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.gm_ack,
         bus.gm_rvalid, bus.gm_rdata, bus.disp_valid, bus.disp_miss, bus.disp_data} !== '0) begin
      fails++; $display("FAIL midclear_reset: got nonzero outputs, required all 0");
    end
    rst = 0;
    tick;
    tick;
    tests++;
    if ({bus.busy_clear, bus.ram_en} !== 2'b00) begin
      fails++; $display("FAIL midclear_idle: busy/en=%b required 00", {bus.busy_clear, bus.ram_en});
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_clear;
    test_game_rw;
    test_disp_stream;
    test_starvation;
    test_clear_conflict;
    test_oor;
    test_reset_mid_clear;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/grid_access_arbiter.md
Name: grid_access_arbiter

Overview:
- Shares the single-port grid cell RAM between three users: the VGA display scan, the snake game logic, and an internal clear sequencer.
- Sits between grid_register's scan path, rect_controller and the grid RAM, all in the clk_65Mhz domain.
- On game_start it wipes the grid, then arbitrates per-cycle RAM slots. Display has priority, and a starvation guard protects game access.

Parameters:
- ADDR_W, 10, grid cell address width.
- DATA_W, 4, cell code width (matches the rect_read_out cell code).
- CELLS, 768, number of valid cells (32x24 grid); valid addresses 0..CELLS-1.
- CLEAR_VAL, 0, cell code written during clear.
- STARVE_MAX, 1024, maximum cycles a pending game request may wait before a forced grant.

Ports:
- clk  in  1  65 MHz pixel clock.
- rst  in  1  synchronous reset, active high.
- game_start  in  1  starts a grid clear when the block is idle.
- disp_req  in  1  display read request, valid one cycle.
- disp_addr  in  ADDR_W  display cell address.
- disp_data  out  DATA_W  display read data.
- disp_valid  out  1  disp_data valid; fixed 3 cycles after disp_req.
- disp_miss  out  1  with disp_valid: the slot was stolen, so disp_data holds its previous value.
- gm_req  in  1  game request; held with gm_we/gm_addr/gm_wdata stable until gm_ack.
- gm_we  in  1  1 = write, 0 = read.
- gm_addr  in  ADDR_W  game cell address.
- gm_wdata  in  DATA_W  game write data.
- gm_ack  out  1  one-cycle pulse when the request is granted.
- gm_rdata  out  DATA_W  game read data.
- gm_rvalid  out  1  one-cycle pulse, 2 cycles after gm_ack, for reads only.
- busy_clear  out  1  high while clear is in progress.
- ram_en  out  1  RAM enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_wdata  out  DATA_W  RAM write data (registered).
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0, starvation counter 0, clear counter 0, in-flight valids discarded.
  - No automatic clear; RAM contents are undefined until game_start.
- State machine has two states, IDLE and CLEAR.
  - IDLE->CLEAR when game_start=1.
  - CLEAR writes CLEAR_VAL at addresses 0..CELLS-1, one per cycle (CELLS cycles).
  - CLEAR->IDLE after writing address CELLS-1.
  - game_start is ignored while in CLEAR.
  - busy_clear equals (state==CLEAR), registered.
- Grant decision in cycle N; RAM signals driven at N+1; ram_rdata at N+2; results registered at N+3.
- Priority, evaluated each cycle N, highest first:
  1. CLEAR.
  2. Forced game grant (wait counter == STARVE_MAX).
  3. disp_req.
  4. gm_req.
- Display timing:
  - Every disp_req yields disp_valid=1 at exactly N+3, regardless of grant.
  - If the request was denied because of CLEAR: disp_data=CLEAR_VAL, disp_miss=0.
  - If the request was denied because of a forced game grant: disp_data keeps its last value, disp_miss=1.
- Game handshake:
  - gm_ack=1 at N+1 for a grant at N.
  - gm_req is ignored in any cycle where gm_ack=1, which prevents a double grant. Maximum game throughput is one transaction per 2 cycles.
  - For reads, gm_rdata is registered and gm_rvalid pulses at N+3.
  - Writes produce no gm_rvalid.
  - gm_req is not acknowledged during CLEAR.
- Starvation guard:
  - The counter increments each cycle gm_req=1, no grant is given and gm_ack=0.
  - It clears on grant or when gm_req=0, and saturates at STARVE_MAX.
- Out-of-range addresses (>= CELLS):
  - Game: acked normally, ram_en=0, and for reads gm_rdata=0 with gm_rvalid still pulsed.
  - Display: disp_valid with disp_data=0, no RAM access.
- When no grant is given, ram_en=0 and ram_we=0.
- Simultaneous game_start and gm_req in IDLE: CLEAR starts that cycle and gm_req waits.
- Reset mid-CLEAR: abort to IDLE; partial clear is permitted.

Test Plan:
- Reset, then game_start pulse: busy_clear high for 768 cycles; ram_we=1 for addresses 0..767 in order with wdata 0; then IDLE with busy_clear=0.
- IDLE, gm_req write addr 5 data 3, then gm_req read addr 5, no disp_req: ack at N+1 for each; read gives gm_rvalid with gm_rdata=3 at ack+2.
- disp_req every cycle, addrs 0..31 preloaded with 0..15 pattern: disp_valid continuous at N+3, data matches, disp_miss=0, gm_ack never asserted while counter < STARVE_MAX.
- disp_req held continuously, gm_req held: gm_ack after exactly STARVE_MAX+1 cycles; the displaced display read shows disp_miss=1 with the held previous data.
- disp_req and gm_req during CLEAR at addr 10: disp_valid with data 0, disp_miss=0; no gm_ack until the clear ends.
- gm_req read addr 800: gm_ack, ram_en stays 0, gm_rvalid with gm_rdata=0; rst asserted mid-CLEAR → next cycle IDLE, all outputs 0.
